// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the issue queue.
// Holds RS entry/issue bundles, opcodes, FU ids and the wakeup snoop helper.
package issue_queue_pkg;

  localparam int RS_DEPTH = 16;
  localparam int NUM_FU   = 3;
  localparam int NUM_WB   = 2;
  localparam int PREG_W   = 6;
  localparam int DATA_W   = 32;
  localparam int ROB_W    = 4;
  localparam int CNT_W    = $clog2(RS_DEPTH + 1);

  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALUR = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  localparam logic [1:0] FU_ALU0 = 2'd0;
  localparam logic [1:0] FU_ALU1 = 2'd1;
  localparam logic [1:0] FU_MEM  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [6:0]        op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              rdy1;
    logic              rdy2;
    logic [1:0]        fu;
    logic [ROB_W-1:0]  rob;
  } rs_entry_t;

  typedef struct packed {
    logic [6:0]        op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [PREG_W-1:0] pd;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ROB_W-1:0]  rob;
  } iss_t;

  // {hit, data}; tag 0 is the hardwired zero register and never wakes.
  function automatic logic [DATA_W:0] snoop(
    input logic [PREG_W-1:0]             tag,
    input logic [NUM_WB-1:0]             v,
    input logic [NUM_WB-1:0][PREG_W-1:0] t,
    input logic [NUM_WB-1:0][DATA_W-1:0] d
  );
    snoop = '0;
    for (int w = 0; w < NUM_WB; w++)
      if (v[w] && t[w] == tag && tag != '0)
        snoop = {1'b1, d[w]};
  endfunction

endpackage

// File: rtl/issue_queue_age_matrix.sv
// Age matrix: age_q[i][j]=1 means entry i is older than entry j.
// Ports: alloc0/alloc1 one-hot per slot, free, per-FU req in, per-FU one-hot gnt out.
module rs_age_matrix
  import issue_queue_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [RS_DEPTH-1:0]              alloc0,
  input  logic [RS_DEPTH-1:0]              alloc1,
  input  logic [RS_DEPTH-1:0]              free,
  input  logic [NUM_FU-1:0][RS_DEPTH-1:0]  req,
  output logic [NUM_FU-1:0][RS_DEPTH-1:0]  gnt
);

  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
  logic [RS_DEPTH-1:0]               alloc;

  assign alloc = alloc0 | alloc1;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < RS_DEPTH; i++)
      if (free[i]) age_d[i] = '0;
    // a new entry is younger than everything; stale bits of
    // invalid rows never matter because req masks them
    for (int j = 0; j < RS_DEPTH; j++)
      if (alloc[j])
        for (int i = 0; i < RS_DEPTH; i++)
          age_d[i][j] = 1'b1;
    for (int j = 0; j < RS_DEPTH; j++)
      if (alloc[j]) age_d[j] = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      for (int j = 0; j < RS_DEPTH; j++)
        if (alloc0[i] && alloc1[j]) age_d[i][j] = 1'b1;
    if (flush) age_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

  always_comb begin
    gnt = '0;
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < RS_DEPTH; i++) begin
        gnt[f][i] = req[f][i];
        for (int j = 0; j < RS_DEPTH; j++)
          if (req[f][j] && age_q[j][i]) gnt[f][i] = 1'b0;
      end
  end

endmodule

// File: rtl/issue_queue.sv
// Reservation station with wakeup and oldest-first select per FU.
// Ports: 2-wide dispatch, NUM_WB wakeup buses, NUM_FU valid/ready issue registers.
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [1:0]                       disp_valid,
  output logic                             disp_ready,
  input  logic [1:0][6:0]                  disp_op,
  input  logic [1:0][2:0]                  disp_func3,
  input  logic [1:0][6:0]                  disp_func7,
  input  logic [1:0][PREG_W-1:0]           disp_ps1,
  input  logic [1:0][PREG_W-1:0]           disp_ps2,
  input  logic [1:0][PREG_W-1:0]           disp_pd,
  input  logic [1:0][DATA_W-1:0]           disp_src1_data,
  input  logic [1:0][DATA_W-1:0]           disp_src2_data,
  input  logic [1:0]                       disp_src1_rdy,
  input  logic [1:0]                       disp_src2_rdy,
  input  logic [1:0][1:0]                  disp_fu_idx,
  input  logic [1:0][ROB_W-1:0]            disp_rob_idx,
  input  logic [NUM_WB-1:0]                wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]    wb_tag,
  input  logic [NUM_WB-1:0][DATA_W-1:0]    wb_data,
  output logic [NUM_FU-1:0]                iss_valid,
  input  logic [NUM_FU-1:0]                iss_ready,
  output logic [NUM_FU-1:0][6:0]           iss_op,
  output logic [NUM_FU-1:0][2:0]           iss_func3,
  output logic [NUM_FU-1:0][6:0]           iss_func7,
  output logic [NUM_FU-1:0][PREG_W-1:0]    iss_pd,
  output logic [NUM_FU-1:0][DATA_W-1:0]    iss_src1,
  output logic [NUM_FU-1:0][DATA_W-1:0]    iss_src2,
  output logic [NUM_FU-1:0][ROB_W-1:0]     iss_rob_idx
);

  rs_entry_t rs_q [RS_DEPTH];
  rs_entry_t rs_d [RS_DEPTH];
  rs_entry_t nw   [2];
  iss_t      iss_q [NUM_FU];
  iss_t      pick  [NUM_FU];

  logic [NUM_FU-1:0]               iss_valid_q;
  logic [RS_DEPTH-1:0]             free0, free1, alloc0, alloc1;
  logic [RS_DEPTH-1:0]             issued;
  logic [CNT_W-1:0]                free_cnt;
  logic [NUM_FU-1:0][RS_DEPTH-1:0] req, gnt;
  logic [NUM_FU-1:0]               load;
  logic [1:0]                      acc;

  // free_count comes from registered valids only, so same-cycle
  // frees never feed allocation
  always_comb begin
    free_cnt = '0;
    free0    = '0;
    free1    = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (!rs_q[i].valid) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (free0 == '0)      free0[i] = 1'b1;
        else if (free1 == '0) free1[i] = 1'b1;
      end
  end

  assign disp_ready = free_cnt >= CNT_W'(2);
  assign acc        = disp_valid & {2{disp_ready & ~flush}};
  assign alloc0     = acc[0] ? free0 : '0;
  assign alloc1     = acc[1] ? free1 : '0;

  always_comb begin : p_new
    logic [DATA_W:0] h1, h2;
    h1 = '0;
    h2 = '0;
    for (int k = 0; k < 2; k++) begin
      h1 = snoop(disp_ps1[k], wb_valid, wb_tag, wb_data);
      h2 = snoop(disp_ps2[k], wb_valid, wb_tag, wb_data);
      nw[k].valid = 1'b1;
      nw[k].op    = disp_op[k];
      nw[k].func3 = disp_func3[k];
      nw[k].func7 = disp_func7[k];
      nw[k].ps1   = disp_ps1[k];
      nw[k].ps2   = disp_ps2[k];
      nw[k].pd    = disp_pd[k];
      nw[k].rdy1  = disp_src1_rdy[k] | h1[DATA_W];
      nw[k].rdy2  = disp_src2_rdy[k] | h2[DATA_W];
      nw[k].src1  = disp_src1_rdy[k] ? disp_src1_data[k]
                                     : h1[DATA_W-1:0];
      nw[k].src2  = disp_src2_rdy[k] ? disp_src2_data[k]
                                     : h2[DATA_W-1:0];
      nw[k].fu    = disp_fu_idx[k];
      nw[k].rob   = disp_rob_idx[k];
    end
  end

  always_comb begin
    req = '0;
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < RS_DEPTH; i++)
        req[f][i] = rs_q[i].valid & rs_q[i].rdy1 & rs_q[i].rdy2
                  & (rs_q[i].fu == 2'(f));
  end

  rs_age_matrix u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .alloc0 (alloc0),
    .alloc1 (alloc1),
    .free   (issued),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    issued = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      load[f] = !iss_valid_q[f] || iss_ready[f];
      if (load[f]) issued = issued | gnt[f];
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      pick[f] = '0;
      for (int i = 0; i < RS_DEPTH; i++)
        if (gnt[f][i]) begin
          pick[f].op    = rs_q[i].op;
          pick[f].func3 = rs_q[i].func3;
          pick[f].func7 = rs_q[i].func7;
          pick[f].pd    = rs_q[i].pd;
          pick[f].src1  = rs_q[i].src1;
          pick[f].src2  = rs_q[i].src2;
          pick[f].rob   = rs_q[i].rob;
        end
    end
  end

  always_comb begin : p_next
    logic [DATA_W:0] h1, h2;
    h1 = '0;
    h2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      rs_d[i] = rs_q[i];
      h1 = snoop(rs_q[i].ps1, wb_valid, wb_tag, wb_data);
      h2 = snoop(rs_q[i].ps2, wb_valid, wb_tag, wb_data);
      if (!rs_q[i].rdy1 && h1[DATA_W]) begin
        rs_d[i].rdy1 = 1'b1;
        rs_d[i].src1 = h1[DATA_W-1:0];
      end
      if (!rs_q[i].rdy2 && h2[DATA_W]) begin
        rs_d[i].rdy2 = 1'b1;
        rs_d[i].src2 = h2[DATA_W-1:0];
      end
      if (issued[i]) rs_d[i].valid = 1'b0;
      if (alloc0[i]) rs_d[i] = nw[0];
      if (alloc1[i]) rs_d[i] = nw[1];
      if (flush)     rs_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) rs_q[i] <= rs_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= '0;
      for (int f = 0; f < NUM_FU; f++) iss_q[f] <= '0;
    end else if (flush) begin
      iss_valid_q <= '0;
      for (int f = 0; f < NUM_FU; f++) iss_q[f] <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++)
        if (load[f]) begin
          iss_valid_q[f] <= |gnt[f];
          if (|gnt[f]) iss_q[f] <= pick[f];
        end
    end
  end

  assign iss_valid = iss_valid_q;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_out
    assign iss_op[f]      = iss_q[f].op;
    assign iss_func3[f]   = iss_q[f].func3;
    assign iss_func7[f]   = iss_q[f].func7;
    assign iss_pd[f]      = iss_q[f].pd;
    assign iss_src1[f]    = iss_q[f].src1;
    assign iss_src2[f]    = iss_q[f].src2;
    assign iss_rob_idx[f] = iss_q[f].rob;
  end

  a_no_disp_when_full: assert property (
    @(posedge clk) disable iff (!rst_n)
    !((|disp_valid) && !disp_ready && !flush));

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue.
// Drives inputs 1 time unit after each rising edge and samples there too.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            flush;
  logic [1:0]                      disp_valid;
  logic                            disp_ready;
  logic [1:0][6:0]                 disp_op;
  logic [1:0][2:0]                 disp_func3;
  logic [1:0][6:0]                 disp_func7;
  logic [1:0][PREG_W-1:0]          disp_ps1, disp_ps2, disp_pd;
  logic [1:0][DATA_W-1:0]          disp_src1_data, disp_src2_data;
  logic [1:0]                      disp_src1_rdy, disp_src2_rdy;
  logic [1:0][1:0]                 disp_fu_idx;
  logic [1:0][ROB_W-1:0]           disp_rob_idx;
  logic [NUM_WB-1:0]               wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0]   wb_tag;
  logic [NUM_WB-1:0][DATA_W-1:0]   wb_data;
  logic [NUM_FU-1:0]               iss_valid;
  logic [NUM_FU-1:0]               iss_ready;
  logic [NUM_FU-1:0][6:0]          iss_op;
  logic [NUM_FU-1:0][2:0]          iss_func3;
  logic [NUM_FU-1:0][6:0]          iss_func7;
  logic [NUM_FU-1:0][PREG_W-1:0]   iss_pd;
  logic [NUM_FU-1:0][DATA_W-1:0]   iss_src1, iss_src2;
  logic [NUM_FU-1:0][ROB_W-1:0]    iss_rob_idx;

  int n_chk = 0;
  int n_err = 0;

  issue_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_op        (disp_op),
    .disp_func3     (disp_func3),
    .disp_func7     (disp_func7),
    .disp_ps1       (disp_ps1),
    .disp_ps2       (disp_ps2),
    .disp_pd        (disp_pd),
    .disp_src1_data (disp_src1_data),
    .disp_src2_data (disp_src2_data),
    .disp_src1_rdy  (disp_src1_rdy),
    .disp_src2_rdy  (disp_src2_rdy),
    .disp_fu_idx    (disp_fu_idx),
    .disp_rob_idx   (disp_rob_idx),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .wb_data        (wb_data),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_op         (iss_op),
    .iss_func3      (iss_func3),
    .iss_func7      (iss_func7),
    .iss_pd         (iss_pd),
    .iss_src1       (iss_src1),
    .iss_src2       (iss_src2),
    .iss_rob_idx    (iss_rob_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_disp();
    disp_valid = '0;
  endtask

  task automatic set_slot(input int k, input logic [6:0] op,
                          input logic [2:0] f3,
                          input logic [PREG_W-1:0] ps1, ps2, pd,
                          input logic [31:0] s1, s2,
                          input logic r1, r2,
                          input logic [1:0] fu,
                          input logic [3:0] rob);
    disp_valid[k]     = 1'b1;
    disp_op[k]        = op;
    disp_func3[k]     = f3;
    disp_func7[k]     = 7'h20;
    disp_ps1[k]       = ps1;
    disp_ps2[k]       = ps2;
    disp_pd[k]        = pd;
    disp_src1_data[k] = s1;
    disp_src2_data[k] = s2;
    disp_src1_rdy[k]  = r1;
    disp_src2_rdy[k]  = r2;
    disp_fu_idx[k]    = fu;
    disp_rob_idx[k]   = rob;
  endtask

  task automatic set_wb(input int p, input logic [PREG_W-1:0] t,
                        input logic [31:0] d);
    wb_valid[p] = 1'b1;
    wb_tag[p]   = t;
    wb_data[p]  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    disp_valid = '0;
    disp_op = '0;
    disp_func3 = '0;
    disp_func7 = '0;
    disp_ps1 = '0;
    disp_ps2 = '0;
    disp_pd = '0;
    disp_src1_data = '0;
    disp_src2_data = '0;
    disp_src1_rdy = '0;
    disp_src2_rdy = '0;
    disp_fu_idx = '0;
    disp_rob_idx = '0;
    wb_valid = '0;
    wb_tag = '0;
    wb_data = '0;
    iss_ready = '1;

    #12;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_src1", iss_src1[0], 0);
    rst_n = 1'b1;
    tick();

    // ADDI with immediate in src2, issue after 2 edges
    set_slot(0, OP_ALUI, 3'd0, 6'd1, 6'd0, 6'd5,
             32'h10, 32'h7, 1'b1, 1'b1, FU_ALU0, 4'd1);
    tick();
    no_disp();
    chk("addi_not_yet", iss_valid[0], 0);
    tick();
    chk("addi_valid", iss_valid[0], 1);
    chk("addi_op", iss_op[0], OP_ALUI);
    chk("addi_src1", iss_src1[0], 32'h10);
    chk("addi_src2", iss_src2[0], 32'h7);
    chk("addi_pd", iss_pd[0], 5);
    chk("addi_rob", iss_rob_idx[0], 1);
    chk("addi_func7", iss_func7[0], 7'h20);
    tick();
    chk("addi_drained", iss_valid[0], 0);

    // ADD waiting on tag 9
    set_slot(0, OP_ALUR, 3'd0, 6'd2, 6'd9, 6'd10,
             32'h3, 32'h0, 1'b1, 1'b0, FU_ALU0, 4'd2);
    tick();
    no_disp();
    tick();
    chk("add_wait", iss_valid[0], 0);
    set_wb(0, 6'd9, 32'h55);
    tick();
    wb_valid = '0;
    chk("add_woken_not_yet", iss_valid[0], 0);
    tick();
    chk("add_valid", iss_valid[0], 1);
    chk("add_src2", iss_src2[0], 32'h55);
    chk("add_src1", iss_src1[0], 32'h3);
    tick();

    // dispatch-cycle bypass for LW on FU2
    set_slot(0, OP_LW, 3'd2, 6'd12, 6'd0, 6'd13,
             32'h0, 32'h4, 1'b0, 1'b1, FU_MEM, 4'd3);
    set_wb(1, 6'd12, 32'hABC);
    tick();
    no_disp();
    wb_valid = '0;
    chk("byp_not_yet", iss_valid[2], 0);
    tick();
    chk("byp_valid", iss_valid[2], 1);
    chk("byp_src1", iss_src1[2], 32'hABC);
    chk("byp_func3", iss_func3[2], 2);
    tick();

    // two FU1 ops, FU1 stalled: oldest first, payload held
    iss_ready[1] = 1'b0;
    set_slot(0, OP_ALUR, 3'd0, 6'd0, 6'd0, 6'd20,
             32'hA1, 32'h1, 1'b1, 1'b1, FU_ALU1, 4'd4);
    set_slot(1, OP_ALUR, 3'd4, 6'd0, 6'd0, 6'd21,
             32'hB2, 32'h2, 1'b1, 1'b1, FU_ALU1, 4'd5);
    tick();
    no_disp();
    tick();
    chk("hold_first_rob", iss_rob_idx[1], 4);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_valid", iss_valid[1], 1);
      chk("hold_rob", iss_rob_idx[1], 4);
      chk("hold_src1", iss_src1[1], 32'hA1);
    end
    iss_ready[1] = 1'b1;
    tick();
    chk("second_valid", iss_valid[1], 1);
    chk("second_rob", iss_rob_idx[1], 5);
    chk("second_src1", iss_src1[1], 32'hB2);
    tick();
    chk("fu1_drained", iss_valid[1], 0);

    // fill 15 entries with unready ops (tags 16+idx)
    for (int p = 0; p < 7; p++) begin
      chk("fill_ready", disp_ready, 1);
      set_slot(0, OP_ALUR, 3'd0, 6'(16 + 2 * p), 6'd0, 6'd0,
               32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'(2 * p));
      set_slot(1, OP_ALUR, 3'd0, 6'(17 + 2 * p), 6'd0, 6'd0,
               32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'(2 * p + 1));
      tick();
      no_disp();
    end
    chk("fill_free2_ready", disp_ready, 1);
    set_slot(0, OP_ALUR, 3'd0, 6'd30, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd14);
    tick();
    no_disp();
    chk("fill_free1_notready", disp_ready, 0);
    set_wb(0, 6'd16, 32'h1234);
    tick();
    wb_valid = '0;
    chk("full_still_notready", disp_ready, 0);
    chk("full_not_issued", iss_valid[0], 0);
    tick();
    chk("full_issue_valid", iss_valid[0], 1);
    chk("full_issue_src1", iss_src1[0], 32'h1234);
    chk("full_issue_rob", iss_rob_idx[0], 0);
    chk("full_ready_again", disp_ready, 1);

    // tag 0 never wakes
    set_slot(0, OP_ALUR, 3'd0, 6'd0, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU1, 4'd15);
    set_wb(0, 6'd0, 32'hDEAD);
    tick();
    no_disp();
    tick();
    wb_valid = '0;
    tick();
    chk("tag0_no_issue", iss_valid[1], 0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_ready", disp_ready, 1);
    chk("flush1_iss", iss_valid, 0);

    // 5 waiting entries plus a stalled FU2 op, then flush
    iss_ready[2] = 1'b0;
    set_slot(0, OP_SW, 3'd2, 6'd0, 6'd0, 6'd0,
             32'h8, 32'h9, 1'b1, 1'b1, FU_MEM, 4'd7);
    set_slot(1, OP_ALUR, 3'd0, 6'd40, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd8);
    tick();
    set_slot(0, OP_ALUR, 3'd0, 6'd41, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd9);
    set_slot(1, OP_ALUR, 3'd0, 6'd42, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd10);
    tick();
    set_slot(0, OP_ALUR, 3'd0, 6'd43, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd11);
    set_slot(1, OP_ALUR, 3'd0, 6'd44, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd12);
    tick();
    no_disp();
    chk("pre_flush_iss2", iss_valid[2], 1);
    chk("pre_flush_rob2", iss_rob_idx[2], 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    iss_ready[2] = 1'b1;
    chk("flush2_iss", iss_valid, 0);
    chk("flush2_ready", disp_ready, 1);
    set_wb(0, 6'd40, 32'h1);
    set_wb(1, 6'd41, 32'h2);
    tick();
    set_wb(0, 6'd42, 32'h3);
    set_wb(1, 6'd43, 32'h4);
    tick();
    set_wb(0, 6'd44, 32'h5);
    wb_valid[1] = 1'b0;
    tick();
    wb_valid = '0;
    chk("flush2_gone_a", iss_valid, 0);
    tick();
    chk("flush2_gone_b", iss_valid, 0);

    // asynchronous reset mid-stream
    iss_ready[2] = 1'b0;
    set_slot(0, OP_LW, 3'd2, 6'd0, 6'd0, 6'd3,
             32'h20, 32'h4, 1'b1, 1'b1, FU_MEM, 4'd9);
    set_slot(1, OP_ALUR, 3'd0, 6'd50, 6'd0, 6'd0,
             32'h0, 32'h0, 1'b0, 1'b1, FU_ALU0, 4'd6);
    tick();
    no_disp();
    tick();
    chk("prerst_iss2", iss_valid[2], 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_iss", iss_valid, 0);
    chk("arst_rob2", iss_rob_idx[2], 0);
    chk("arst_ready", disp_ready, 1);
    #2;
    rst_n = 1'b1;
    iss_ready[2] = 1'b1;
    tick();
    set_wb(0, 6'd50, 32'h77);
    tick();
    wb_valid = '0;
    tick();
    chk("arst_gone", iss_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
